// File: rtl/ex_mem_stage_pkg.sv
// ex_mem_stage_pkg
// Shared definitions for the EX/MEM pipeline stage:
//   - default datapath and register-address widths
//   - ALU operation encodings
//   - condition-code bit positions inside the 3-bit CCR {C,N,Z}
//   - helper that builds the CCR value written by a flag-updating ALU op
package ex_mem_stage_pkg;

  localparam int N_DEFAULT  = 16;
  localparam int RW_DEFAULT = 3;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'd0,
    ALU_NOT  = 2'd1,
    ALU_PASS = 2'd2,
    ALU_NOP  = 2'd3
  } alu_op_e;

  localparam int CCR_C = 2;
  localparam int CCR_N = 1;
  localparam int CCR_Z = 0;

  // CCR produced by a flag-updating op; PASS never produces a carry and
  // setc/clrc override only the carry (setc has priority).
  function automatic logic [2:0] alu_ccr(input alu_op_e op,
                                         input logic    carry,
                                         input logic    neg,
                                         input logic    zero,
                                         input logic    setc,
                                         input logic    clrc);
    logic [2:0] res;
    res        = 3'b000;
    res[CCR_Z] = zero;
    res[CCR_N] = neg;
    res[CCR_C] = (op == ALU_PASS) ? 1'b0 : carry;
    if (setc) begin
      res[CCR_C] = 1'b1;
    end else if (clrc) begin
      res[CCR_C] = 1'b0;
    end else begin
      res[CCR_C] = res[CCR_C];
    end
    return res;
  endfunction

endpackage

// File: rtl/ex_mem_stage_ccr_unit.sv
// ccr_unit
// Condition-code register with interrupt shadow copy.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   load                            pipeline register is loading this cycle
//   in_valid, alu_op                instruction qualifiers from EX
//   carry_in, neg_in, zero_in       ALU flags
//   setc, clrc                      explicit carry set / clear
//   flag_save, flag_restore         interrupt entry / RTI
//   ccr, ccr_shadow                 registered {C,N,Z} and its saved copy
module ccr_unit
  import ex_mem_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       in_valid,
  input  logic [1:0] alu_op,
  input  logic       carry_in,
  input  logic       neg_in,
  input  logic       zero_in,
  input  logic       setc,
  input  logic       clrc,
  input  logic       flag_save,
  input  logic       flag_restore,
  output logic [2:0] ccr,
  output logic [2:0] ccr_shadow
);

  logic [2:0] ccr_r;
  logic [2:0] shadow_r;
  logic [2:0] ccr_next_s;
  logic       live_s;

  // Only a real instruction that actually enters MEM may touch the flags.
  assign live_s = load & in_valid;

  // Next CCR from the instruction: full update for flag ops, carry-only
  // update for setc/clrc riding on a NOP, otherwise hold.
  always_comb begin
    ccr_next_s = ccr_r;
    if (live_s && (alu_op != ALU_NOP)) begin
      ccr_next_s = alu_ccr(alu_op_e'(alu_op), carry_in, neg_in, zero_in, setc, clrc);
    end else if (live_s && (setc || clrc)) begin
      ccr_next_s[CCR_C] = setc;
    end else begin
      ccr_next_s = ccr_r;
    end
  end

  // CCR and shadow registers; restore beats any instruction update and
  // suppresses a simultaneous save.
  always_ff @(posedge clk) begin
    if (rst) begin
      ccr_r    <= 3'b000;
      shadow_r <= 3'b000;
    end else begin
      if (flag_restore) begin
        ccr_r <= shadow_r;
      end else begin
        ccr_r <= ccr_next_s;
      end
      if (flag_save && !flag_restore) begin
        shadow_r <= ccr_r;
      end else begin
        shadow_r <= shadow_r;
      end
    end
  end

  assign ccr        = ccr_r;
  assign ccr_shadow = shadow_r;

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage
// EX/MEM pipeline register with condition-code handling.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall, flush             hold / bubble-insert controls (flush wins)
//   in_valid, alu_out, flags, alu_op, ex_* fields    EX-side inputs
//   flag_save, flag_restore, setc, clrc               CCR controls
//   mem_valid, mem_*         registered MEM-side outputs (1-cycle latency)
//   ccr, ccr_shadow          condition codes {C,N,Z} and saved copy
//   fwd_data                 forwarding copy of mem_alu_out
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int RW = RW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [N-1:0]  alu_out,
  input  logic          carry_in,
  input  logic          zero_in,
  input  logic          neg_in,
  input  logic [1:0]    alu_op,
  input  logic [RW-1:0] ex_rdst,
  input  logic          ex_wb_en,
  input  logic          ex_mem_rd,
  input  logic          ex_mem_wr,
  input  logic [N-1:0]  ex_store_data,
  input  logic          flag_save,
  input  logic          flag_restore,
  input  logic          setc,
  input  logic          clrc,
  output logic          mem_valid,
  output logic [N-1:0]  mem_alu_out,
  output logic [N-1:0]  mem_store_data,
  output logic [RW-1:0] mem_rdst,
  output logic          mem_wb_en,
  output logic          mem_mem_rd,
  output logic          mem_mem_wr,
  output logic [2:0]    ccr,
  output logic [2:0]    ccr_shadow,
  output logic [N-1:0]  fwd_data
);

  logic load_s;

  assign load_s = ~flush & ~stall;

  // Pipeline register: rst > flush > stall > load. Control bits of a
  // bubble are forced low so MEM/WB never act on it.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      mem_valid      <= 1'b0;
      mem_alu_out    <= {N{1'b0}};
      mem_store_data <= {N{1'b0}};
      mem_rdst       <= {RW{1'b0}};
      mem_wb_en      <= 1'b0;
      mem_mem_rd     <= 1'b0;
      mem_mem_wr     <= 1'b0;
    end else if (stall) begin
      mem_valid      <= mem_valid;
      mem_alu_out    <= mem_alu_out;
      mem_store_data <= mem_store_data;
      mem_rdst       <= mem_rdst;
      mem_wb_en      <= mem_wb_en;
      mem_mem_rd     <= mem_mem_rd;
      mem_mem_wr     <= mem_mem_wr;
    end else begin
      mem_valid      <= in_valid;
      mem_alu_out    <= alu_out;
      mem_store_data <= ex_store_data;
      mem_rdst       <= ex_rdst;
      mem_wb_en      <= ex_wb_en & in_valid;
      mem_mem_rd     <= ex_mem_rd & in_valid;
      mem_mem_wr     <= ex_mem_wr & in_valid;
    end
  end

  ccr_unit u_ccr (
    .clk          (clk),
    .rst          (rst),
    .load         (load_s),
    .in_valid     (in_valid),
    .alu_op       (alu_op),
    .carry_in     (carry_in),
    .neg_in       (neg_in),
    .zero_in      (zero_in),
    .setc         (setc),
    .clrc         (clrc),
    .flag_save    (flag_save),
    .flag_restore (flag_restore),
    .ccr          (ccr),
    .ccr_shadow   (ccr_shadow)
  );

  assign fwd_data = mem_alu_out;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage
// Directed scenarios plus randomized stimulus, every cycle compared against
// a behavioural model of the stage kept in the bench.
module tb_ex_mem_stage;

  localparam int N  = 16;
  localparam int RW = 3;

  logic          clk = 1'b0;
  logic          rst, stall, flush, in_valid;
  logic [N-1:0]  alu_out, ex_store_data;
  logic          carry_in, zero_in, neg_in;
  logic [1:0]    alu_op;
  logic [RW-1:0] ex_rdst;
  logic          ex_wb_en, ex_mem_rd, ex_mem_wr;
  logic          flag_save, flag_restore, setc, clrc;
  logic          mem_valid, mem_wb_en, mem_mem_rd, mem_mem_wr;
  logic [N-1:0]  mem_alu_out, mem_store_data, fwd_data;
  logic [RW-1:0] mem_rdst;
  logic [2:0]    ccr, ccr_shadow;

  int checks = 0;
  int errors = 0;

  // reference state
  logic          m_valid, m_wb, m_rd, m_wr;
  logic [N-1:0]  m_alu, m_sd;
  logic [RW-1:0] m_rdst;
  logic [2:0]    m_ccr, m_sh;

  ex_mem_stage #(.N(N), .RW(RW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .alu_out(alu_out), .carry_in(carry_in), .zero_in(zero_in), .neg_in(neg_in),
    .alu_op(alu_op), .ex_rdst(ex_rdst), .ex_wb_en(ex_wb_en), .ex_mem_rd(ex_mem_rd),
    .ex_mem_wr(ex_mem_wr), .ex_store_data(ex_store_data), .flag_save(flag_save),
    .flag_restore(flag_restore), .setc(setc), .clrc(clrc), .mem_valid(mem_valid),
    .mem_alu_out(mem_alu_out), .mem_store_data(mem_store_data), .mem_rdst(mem_rdst),
    .mem_wb_en(mem_wb_en), .mem_mem_rd(mem_mem_rd), .mem_mem_wr(mem_mem_wr),
    .ccr(ccr), .ccr_shadow(ccr_shadow), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Spec-level model of one rising edge, using the inputs applied before it.
  task automatic model_edge();
    logic [2:0] old_ccr;
    logic c, n, z;
    if (rst) begin
      m_valid = 1'b0; m_alu = '0; m_sd = '0; m_rdst = '0;
      m_wb = 1'b0; m_rd = 1'b0; m_wr = 1'b0; m_ccr = 3'b000; m_sh = 3'b000;
    end else begin
      old_ccr = m_ccr;
      if (flush) begin
        m_valid = 1'b0; m_alu = '0; m_sd = '0; m_rdst = '0;
        m_wb = 1'b0; m_rd = 1'b0; m_wr = 1'b0;
      end else if (!stall) begin
        m_valid = in_valid; m_alu = alu_out; m_sd = ex_store_data; m_rdst = ex_rdst;
        m_wb = in_valid && ex_wb_en; m_rd = in_valid && ex_mem_rd; m_wr = in_valid && ex_mem_wr;
      end
      if (flag_restore) begin
        m_ccr = m_sh;
      end else if (!flush && !stall && in_valid) begin
        c = m_ccr[2]; n = m_ccr[1]; z = m_ccr[0];
        if (alu_op != 2'd3) begin
          z = zero_in; n = neg_in;
          c = (alu_op == 2'd2) ? 1'b0 : carry_in;
        end
        if (setc) c = 1'b1;
        else if (clrc) c = 1'b0;
        m_ccr = {c, n, z};
      end
      if (flag_save && !flag_restore) m_sh = old_ccr;
    end
  endtask

  task automatic compare_all();
    check_eq("mem_valid", 32'(mem_valid), 32'(m_valid));
    check_eq("mem_alu_out", 32'(mem_alu_out), 32'(m_alu));
    check_eq("mem_store_data", 32'(mem_store_data), 32'(m_sd));
    check_eq("mem_rdst", 32'(mem_rdst), 32'(m_rdst));
    check_eq("mem_wb_en", 32'(mem_wb_en), 32'(m_wb));
    check_eq("mem_mem_rd", 32'(mem_mem_rd), 32'(m_rd));
    check_eq("mem_mem_wr", 32'(mem_mem_wr), 32'(m_wr));
    check_eq("ccr", 32'(ccr), 32'(m_ccr));
    check_eq("ccr_shadow", 32'(ccr_shadow), 32'(m_sh));
    check_eq("fwd_data", 32'(fwd_data), 32'(m_alu));
  endtask

  // One clock: model the edge, then sample outputs 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic set_idle();
    rst = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    alu_out = '0; ex_store_data = '0; carry_in = 1'b0; zero_in = 1'b0; neg_in = 1'b0;
    alu_op = 2'd3; ex_rdst = '0; ex_wb_en = 1'b0; ex_mem_rd = 1'b0; ex_mem_wr = 1'b0;
    flag_save = 1'b0; flag_restore = 1'b0; setc = 1'b0; clrc = 1'b0;
  endtask

  task automatic set_random_data();
    in_valid = 1'($urandom); alu_out = N'($urandom); ex_store_data = N'($urandom);
    carry_in = 1'($urandom); zero_in = 1'($urandom); neg_in = 1'($urandom);
    alu_op = 2'($urandom); ex_rdst = RW'($urandom);
    ex_wb_en = 1'($urandom); ex_mem_rd = 1'($urandom); ex_mem_wr = 1'($urandom);
  endtask

  task automatic alu_load(input logic [1:0] op, input logic c, input logic n, input logic z);
    set_idle();
    in_valid = 1'b1; alu_op = op; carry_in = c; neg_in = n; zero_in = z;
    alu_out = N'($urandom); ex_rdst = RW'($urandom); ex_wb_en = 1'b1;
    step();
  endtask

  logic [N-1:0] held_alu;
  logic [2:0]   held_ccr;

  initial begin
    set_idle();
    m_ccr = 3'bxxx; m_sh = 3'bxxx;

    // reset with junk on the inputs
    set_random_data();
    rst = 1'b1; flag_restore = 1'b1;
    step();
    check_eq("reset_ccr", 32'(ccr), 32'h0);
    check_eq("reset_valid", 32'(mem_valid), 32'h0);

    // load add: zero result with carry
    set_idle();
    in_valid = 1'b1; alu_op = 2'd0; alu_out = 16'h0000; carry_in = 1'b1; zero_in = 1'b1;
    step();
    check_eq("add_alu_out", 32'(mem_alu_out), 32'h0);
    check_eq("add_ccr", 32'(ccr), 32'h5);

    // stall two cycles with changing inputs, then flush during stall
    alu_load(2'd1, 1'b0, 1'b1, 1'b0);
    held_alu = mem_alu_out; held_ccr = ccr;
    for (int i = 0; i < 2; i++) begin
      set_random_data(); stall = 1'b1; in_valid = 1'b1; alu_op = 2'd0;
      setc = 1'b1;
      step();
      check_eq("stall_alu", 32'(mem_alu_out), 32'(held_alu));
      check_eq("stall_ccr", 32'(ccr), 32'(held_ccr));
      check_eq("stall_valid", 32'(mem_valid), 32'h1);
    end
    flush = 1'b1;
    step();
    check_eq("flush_in_stall_valid", 32'(mem_valid), 32'h0);
    check_eq("flush_in_stall_ccr", 32'(ccr), 32'(held_ccr));

    // NOP holds flags; setc forces C on a NOT op
    alu_load(2'd0, 1'b0, 1'b1, 1'b0);
    check_eq("ccr_010", 32'(ccr), 32'h2);
    alu_load(2'd3, 1'b0, 1'b0, 1'b1);
    check_eq("nop_hold", 32'(ccr), 32'h2);
    set_idle(); in_valid = 1'b1; alu_op = 2'd1; carry_in = 1'b0; setc = 1'b1;
    step();
    check_eq("setc_c", 32'(ccr[2]), 32'h1);
    set_idle(); in_valid = 1'b1; alu_op = 2'd2; carry_in = 1'b1; neg_in = 1'b1;
    step();
    check_eq("pass_clears_c", 32'(ccr), 32'h2);

    // interrupt save / restore
    alu_load(2'd0, 1'b1, 1'b1, 1'b0);
    check_eq("ccr_110", 32'(ccr), 32'h6);
    set_idle(); flag_save = 1'b1;
    step();
    check_eq("save_shadow", 32'(ccr_shadow), 32'h6);
    alu_load(2'd0, 1'b0, 1'b0, 1'b1);
    check_eq("ccr_001", 32'(ccr), 32'h1);
    set_idle(); flag_restore = 1'b1; in_valid = 1'b1; alu_op = 2'd0; zero_in = 1'b1;
    step();
    check_eq("restore_ccr", 32'(ccr), 32'h6);
    set_idle(); flag_save = 1'b1; flag_restore = 1'b1; in_valid = 1'b1; alu_op = 2'd0; zero_in = 1'b1;
    step();
    check_eq("save_restore_ccr", 32'(ccr), 32'h6);
    check_eq("save_restore_shadow", 32'(ccr_shadow), 32'h6);
    // save ignored when restoring: change ccr, then save+restore
    alu_load(2'd0, 1'b0, 1'b0, 1'b1);
    set_idle(); flag_save = 1'b1; flag_restore = 1'b1;
    step();
    check_eq("sr_shadow_kept", 32'(ccr_shadow), 32'h6);
    check_eq("sr_ccr", 32'(ccr), 32'h6);

    // reset mid-operation overrides everything
    alu_load(2'd0, 1'b1, 1'b1, 1'b1);
    set_random_data(); rst = 1'b1; flush = 1'b1; stall = 1'b1; flag_restore = 1'b1;
    step();
    check_eq("rst_mid_valid", 32'(mem_valid), 32'h0);
    check_eq("rst_mid_alu", 32'(mem_alu_out), 32'h0);
    check_eq("rst_mid_ccr", 32'(ccr), 32'h0);
    check_eq("rst_mid_shadow", 32'(ccr_shadow), 32'h0);
    set_idle(); in_valid = 1'b1; alu_op = 2'd0; alu_out = 16'hBEEF; ex_mem_wr = 1'b1;
    step();
    check_eq("post_rst_valid", 32'(mem_valid), 32'h1);
    check_eq("post_rst_alu", 32'(mem_alu_out), 32'hBEEF);
    check_eq("post_rst_wr", 32'(mem_mem_wr), 32'h1);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      set_random_data();
      rst          = ($urandom_range(0, 63) == 0);
      flush        = ($urandom_range(0, 7) == 0);
      stall        = ($urandom_range(0, 5) == 0);
      flag_save    = ($urandom_range(0, 7) == 0);
      flag_restore = ($urandom_range(0, 7) == 0);
      setc         = ($urandom_range(0, 7) == 0) && (alu_op != 2'd3);
      clrc         = ($urandom_range(0, 7) == 0) && (alu_op != 2'd3);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
